// File: rtl/spw_credit_pkg.sv
// Shared constants and types for the SpaceWire link-level credit tracker.
package spw_credit_pkg;

  localparam int unsigned MAX_CREDIT = 56;
  localparam int unsigned FCT_INC    = 8;

  typedef logic [1:0] err_cause_t;
  localparam err_cause_t ERR_NONE   = 2'b00;
  localparam err_cause_t ERR_TX_OVF = 2'b01;
  localparam err_cause_t ERR_TX_UNF = 2'b10;
  localparam err_cause_t ERR_RX_OVF = 2'b11;

  typedef logic [0:0] fct_state_t;
  localparam fct_state_t ST_IDLE = 1'b0;
  localparam fct_state_t ST_REQ  = 1'b1;

endpackage

// File: rtl/spw_credit_sat_cnt.sv
// Credit counter: +FCT_INC on inc, -1 on dec; holds and flags on overflow/underflow.
module spw_credit_sat_cnt #(
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned MAX_CREDIT = spw_credit_pkg::MAX_CREDIT,
  parameter int unsigned FCT_INC    = spw_credit_pkg::FCT_INC
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             overflow,
  output logic             underflow
);

  // Two spare bits so the sum neither wraps on +FCT_INC nor aliases on 0-1.
  localparam int unsigned SUM_W = CNT_W + 2;

  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] count_q, count_d;
  logic             nonzero_q;

  always_comb begin
    sum = SUM_W'(count_q);
    if (inc) sum = sum + SUM_W'(FCT_INC);
    if (dec) sum = sum - SUM_W'(1);
    underflow = !clr && dec && !inc && (count_q == '0);
    overflow  = !clr && !underflow && (sum > SUM_W'(MAX_CREDIT));
    if (clr) begin
      count_d = '0;
    end else if (overflow || underflow) begin
      count_d = count_q;
    end else begin
      count_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      nonzero_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      nonzero_q <= (count_d != '0);
    end
  end

  assign count   = count_q;
  assign nonzero = nonzero_q;

endmodule

// File: rtl/spw_credit_counter.sv
// SpaceWire flow-control credit tracker: tx/rx credit counters, FCT request FSM, error latch.
module spw_credit_counter #(
  parameter int unsigned MAX_CREDIT = spw_credit_pkg::MAX_CREDIT,
  parameter int unsigned FCT_INC    = spw_credit_pkg::FCT_INC,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             link_run,
  input  logic             fct_rx,
  input  logic             nchar_tx,
  input  logic             rx_nchar,
  input  logic [6:0]       rx_buf_free,
  input  logic             fct_tx_ack,
  output logic [CNT_W-1:0] tx_credit,
  output logic             tx_credit_ok,
  output logic [CNT_W-1:0] rx_outstanding,
  output logic             fct_tx_req,
  output logic             credit_error,
  output logic [1:0]       error_cause
);

  import spw_credit_pkg::*;

  fct_state_t state_q, state_d;
  logic       err_q, err_d;
  err_cause_t cause_q, cause_d;

  logic       tx_ovf, tx_unf, rx_ovf, rx_unf;
  logic       rx_inc, new_err, fct_room;
  logic [7:0] need;
  logic       unused_rx_nonzero;

  spw_credit_sat_cnt #(
    .CNT_W      (CNT_W),
    .MAX_CREDIT (MAX_CREDIT),
    .FCT_INC    (FCT_INC)
  ) u_tx_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (!link_run),
    .inc       (fct_rx),
    .dec       (nchar_tx),
    .count     (tx_credit),
    .nonzero   (tx_credit_ok),
    .overflow  (tx_ovf),
    .underflow (tx_unf)
  );

  // Ack only grants credit while a request is actually outstanding.
  assign rx_inc = fct_tx_ack && (state_q == ST_REQ);

  spw_credit_sat_cnt #(
    .CNT_W      (CNT_W),
    .MAX_CREDIT (MAX_CREDIT),
    .FCT_INC    (FCT_INC)
  ) u_rx_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (!link_run),
    .inc       (rx_inc),
    .dec       (rx_nchar),
    .count     (rx_outstanding),
    .nonzero   (unused_rx_nonzero),
    .overflow  (rx_ovf),
    .underflow (rx_unf)
  );

  assign new_err  = tx_ovf || tx_unf || rx_ovf || rx_unf;
  assign need     = 8'(rx_outstanding) + 8'(FCT_INC);
  assign fct_room = (rx_outstanding <= CNT_W'(MAX_CREDIT - FCT_INC)) &&
                    ({1'b0, rx_buf_free} >= need);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cause_d = cause_q;
    if (!link_run) begin
      state_d = ST_IDLE;
      err_d   = 1'b0;
      cause_d = ERR_NONE;
    end else begin
      if (new_err) begin
        err_d = 1'b1;
        if (!err_q) begin
          if (tx_ovf)      cause_d = ERR_TX_OVF;
          else if (tx_unf) cause_d = ERR_TX_UNF;
          else             cause_d = ERR_RX_OVF;
        end
      end
      case (state_q)
        ST_IDLE: if (!err_q && !new_err && fct_room) state_d = ST_REQ;
        ST_REQ:  if (fct_tx_ack || new_err) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      cause_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  end

  assign fct_tx_req   = (state_q == ST_REQ);
  assign credit_error = err_q;
  assign error_cause  = cause_q;

endmodule

// File: tb/tb_spw_credit_counter.sv
// Directed plus randomized check of spw_credit_counter against a cycle-level credit model.
module tb_spw_credit_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       link_run = 1'b0;
  logic       fct_rx = 1'b0;
  logic       nchar_tx = 1'b0;
  logic       rx_nchar = 1'b0;
  logic       fct_tx_ack = 1'b0;
  logic [6:0] rx_buf_free = 7'd0;

  logic [5:0] tx_credit;
  logic       tx_credit_ok;
  logic [5:0] rx_outstanding;
  logic       fct_tx_req;
  logic       credit_error;
  logic [1:0] error_cause;

  int checks = 0;
  int failures = 0;

  int m_tx, m_rx, m_cause;
  bit m_err, m_req;

  spw_credit_counter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .link_run       (link_run),
    .fct_rx         (fct_rx),
    .nchar_tx       (nchar_tx),
    .rx_nchar       (rx_nchar),
    .rx_buf_free    (rx_buf_free),
    .fct_tx_ack     (fct_tx_ack),
    .tx_credit      (tx_credit),
    .tx_credit_ok   (tx_credit_ok),
    .rx_outstanding (rx_outstanding),
    .fct_tx_req     (fct_tx_req),
    .credit_error   (credit_error),
    .error_cause    (error_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Credit bookkeeping from the link-level rules, one step per clock edge.
  always @(posedge clk or negedge reset_n) begin : model
    int ntx, nrx, cause_now;
    bit e_ovf, e_unf, e_rx, any_err, ack_eff, room;
    if (!reset_n) begin
      m_tx <= 0; m_rx <= 0; m_err <= 0; m_cause <= 0; m_req <= 0;
    end else if (!link_run) begin
      m_tx <= 0; m_rx <= 0; m_err <= 0; m_cause <= 0; m_req <= 0;
    end else begin
      ntx     = m_tx + (fct_rx ? 8 : 0) - (nchar_tx ? 1 : 0);
      e_ovf   = ntx > 56;
      e_unf   = ntx < 0;
      ack_eff = fct_tx_ack && m_req;
      nrx     = m_rx + (ack_eff ? 8 : 0) - (rx_nchar ? 1 : 0);
      e_rx    = (nrx < 0) || (nrx > 56);
      any_err = e_ovf || e_unf || e_rx;
      if (!e_ovf && !e_unf) m_tx <= ntx;
      if (!e_rx) m_rx <= nrx;
      cause_now = e_ovf ? 1 : (e_unf ? 2 : 3);
      if (any_err && !m_err) m_cause <= cause_now;
      if (any_err) m_err <= 1'b1;
      room = (m_rx <= 48) && (int'(rx_buf_free) >= m_rx + 8);
      if (m_req) m_req <= !(fct_tx_ack || any_err);
      else       m_req <= !m_err && !any_err && room;
    end
  end

  always @(negedge clk) begin
    check("tx_credit", int'(tx_credit), m_tx);
    check("tx_credit_ok", int'(tx_credit_ok), (m_tx != 0) ? 1 : 0);
    check("rx_outstanding", int'(rx_outstanding), m_rx);
    check("fct_tx_req", int'(fct_tx_req), int'(m_req));
    check("credit_error", int'(credit_error), int'(m_err));
    check("error_cause", int'(error_cause), m_cause);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_link();
    link_run = 1'b0;
    tick();
    link_run = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx"}, int'(tx_credit), 0);
    check({tag, "_ok"}, int'(tx_credit_ok), 0);
    check({tag, "_rx"}, int'(rx_outstanding), 0);
    check({tag, "_req"}, int'(fct_tx_req), 0);
    check({tag, "_err"}, int'(credit_error), 0);
    check({tag, "_cause"}, int'(error_cause), 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset_n  = 1'b1;
    link_run = 1'b1;

    // Fill tx credit to the maximum, then overflow it.
    repeat (7) begin fct_rx = 1'b1; tick(); end
    fct_rx = 1'b0;
    check("fill_tx", int'(tx_credit), 56);
    check("fill_err", int'(credit_error), 0);
    fct_rx = 1'b1; tick(); fct_rx = 1'b0;
    check("ovf_tx", int'(tx_credit), 56);
    check("ovf_err", int'(credit_error), 1);
    check("ovf_cause", int'(error_cause), 1);

    // Spend 8 credits down to zero, then underflow.
    clear_link();
    fct_rx = 1'b1; tick(); fct_rx = 1'b0;
    check("spend_start", int'(tx_credit), 8);
    nchar_tx = 1'b1;
    repeat (8) tick();
    check("spend_tx", int'(tx_credit), 0);
    check("spend_ok", int'(tx_credit_ok), 0);
    check("spend_err", int'(credit_error), 0);
    tick(); nchar_tx = 1'b0;
    check("unf_tx", int'(tx_credit), 0);
    check("unf_cause", int'(error_cause), 2);

    // Simultaneous FCT and N-char at zero credit is a net +7.
    clear_link();
    fct_rx = 1'b1; nchar_tx = 1'b1; tick(); fct_rx = 1'b0; nchar_tx = 1'b0;
    check("both_tx", int'(tx_credit), 7);
    check("both_ok", int'(tx_credit_ok), 1);
    check("both_err", int'(credit_error), 0);

    // FCT requests against 20 free receive entries: two grants, then none.
    link_run = 1'b0; rx_buf_free = 7'd20; tick(); link_run = 1'b1;
    tick();
    check("req1", int'(fct_tx_req), 1);
    tick();
    check("req1_hold", int'(fct_tx_req), 1);
    fct_tx_ack = 1'b1; tick(); fct_tx_ack = 1'b0;
    check("ack1_req", int'(fct_tx_req), 0);
    check("ack1_out", int'(rx_outstanding), 8);
    tick();
    check("req2", int'(fct_tx_req), 1);
    fct_tx_ack = 1'b1; tick(); fct_tx_ack = 1'b0;
    check("ack2_out", int'(rx_outstanding), 16);
    tick(); tick();
    check("req3_none", int'(fct_tx_req), 0);
    check("req3_out", int'(rx_outstanding), 16);

    // Receive overflow blocks requests; dropping link_run clears everything.
    link_run = 1'b0; rx_buf_free = 7'd0; tick(); link_run = 1'b1;
    rx_nchar = 1'b1; tick(); rx_nchar = 1'b0;
    check("rxovf_err", int'(credit_error), 1);
    check("rxovf_cause", int'(error_cause), 3);
    rx_buf_free = 7'd127; tick(); tick();
    check("rxovf_noreq", int'(fct_tx_req), 0);
    link_run = 1'b0; tick();
    check_all_zero("linkdown");

    // Asynchronous reset while a request is pending with nonzero counts.
    link_run = 1'b1; fct_rx = 1'b1; tick(); fct_rx = 1'b0;
    check("pre_tx", int'(tx_credit), 8);
    check("pre_req", int'(fct_tx_req), 1);
    fct_tx_ack = 1'b1; tick(); fct_tx_ack = 1'b0;
    tick();
    check("pre_rx", int'(rx_outstanding), 8);
    check("pre_req2", int'(fct_tx_req), 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async");
    rx_buf_free = 7'd0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_idle", int'(fct_tx_req), 0);
    fct_tx_ack = 1'b1; tick(); fct_tx_ack = 1'b0;
    check("idle_ack_ignored", int'(rx_outstanding), 0);

    // Randomized traffic, checked every cycle by the model compare.
    for (int i = 0; i < 3000; i++) begin
      link_run   = ($urandom_range(0, 39) != 0);
      fct_rx     = ($urandom_range(0, 3) == 0);
      nchar_tx   = ($urandom_range(0, 2) == 0);
      rx_nchar   = ($urandom_range(0, 4) == 0);
      fct_tx_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) rx_buf_free = 7'($urandom_range(0, 127));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spw_credit_counter.md
# spw_credit_counter

SpaceWire link-level flow-control credit tracker for the JAXA SpW core.
- Transmit side: counts the N-char credit granted by the far end through received FCTs and spends it as N-chars are sent.
- Receive side: counts credit granted to the far end and requests FCT transmission when local buffer space allows.
- Its registered `tx_credit` output is the 6-bit value wired to the Avalon credit-count input port that software polls.

## Interface
Parameters:
- `MAX_CREDIT`, 56: maximum outstanding credit per direction (ECSS-E-ST-50-12C).
- `FCT_INC`, 8: N-chars granted per FCT.
- `CNT_W`, 6: counter width; must hold `MAX_CREDIT`.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `link_run`  in  1  link FSM in Run state; low = synchronous clear of both counters and errors.
- `fct_rx`  in  1  single-cycle pulse, FCT received from far end.
- `nchar_tx`  in  1  single-cycle pulse, N-char (data/EOP/EEP) transmitted.
- `rx_nchar`  in  1  single-cycle pulse, N-char received.
- `rx_buf_free`  in  7  free entries in the receive FIFO, 0..127.
- `fct_tx_ack`  in  1  transmitter accepted the FCT request; single cycle.
- `tx_credit`  out  `CNT_W`  current transmit credit, 0..56.
- `tx_credit_ok`  out  1  `tx_credit != 0`, registered.
- `rx_outstanding`  out  `CNT_W`  credit granted to far end not yet consumed.
- `fct_tx_req`  out  1  request to send one FCT.
- `credit_error`  out  1  sticky credit error; drives link disconnect upstream.
- `error_cause`  out  2  00 none, 01 tx overflow, 10 tx underflow, 11 rx overflow; first error only.

## Operation
- All outputs are registered. Reset value of every output is 0.
- `link_run` = 0 is a synchronous clear: counters, `fct_tx_req`, `credit_error` and `error_cause` all go to 0 on the next edge. This overrides all other inputs.
- Transmit counter, delta per cycle = `+FCT_INC·fct_rx − nchar_tx`:
  - both pulses in the same cycle → net +7.
  - Overflow: the result would exceed 56 (e.g. `fct_rx` at 49..56 without `nchar_tx`). The counter holds its value, `credit_error` sets, cause 01.
  - Underflow: `nchar_tx` at 0 without `fct_rx`. The counter holds at 0, `credit_error` sets, cause 10.
  - `nchar_tx` together with `fct_rx` at 0 → 7, legal.
- Receive counter, delta per cycle = `+FCT_INC·fct_tx_ack − rx_nchar`:
  - `rx_nchar` at 0 without ack is an rx overflow (far end sent beyond its credit). The counter holds, `credit_error` sets, cause 11.
- FCT request FSM, states IDLE and REQ:
  - IDLE → REQ when `link_run`, `!credit_error`, `rx_outstanding` ≤ 48, and `rx_buf_free` ≥ `rx_outstanding` + 8. Compare in 7 bits, no truncation.
  - REQ holds `fct_tx_req` = 1 until `fct_tx_ack`. On the ack edge, `rx_outstanding` += 8 and the FSM returns to IDLE.
  - IDLE lasts at least one cycle before re-evaluation, so consecutive FCTs are ≥ 2 cycles apart.
  - Ack while in IDLE is ignored; it does not change the counter.
- `credit_error` stays set until `link_run` falls. Counters keep updating legal deltas after an error. Only the first cause is recorded.
- After an error, `fct_tx_req` stays low. If REQ is active when the error occurs, the FSM drops to IDLE.

## Timing
- Pulse at edge N → counters and flags updated at edge N+1. Latency 1 cycle.
- `tx_credit_ok` and `credit_error` update in the same cycle as the counter.
- `fct_tx_req` rises 1 cycle after its condition is met in IDLE. It falls 1 cycle after `fct_tx_ack`.
- Reset mid-operation: asynchronous clear of all state, FSM to IDLE. Outputs read 0 immediately.

## Structure
- Shared package `spw_credit_pkg` holds:
  - `MAX_CREDIT`, `FCT_INC` and the `error_cause` encodings.
  - The FSM state typedef.
- One sub-module, `spw_credit_sat_cnt`: an up-by-`FCT_INC`/down-by-1 counter with overflow/underflow flags. It is instantiated twice, for tx and rx. The top level holds the FCT FSM and the error latch.

## Test plan
- Reset, `link_run` = 1, 7 `fct_rx` pulses → `tx_credit` 56, no error. An 8th pulse → `tx_credit` 56, `credit_error` 1, cause 01.
- `tx_credit` 8, then 8 `nchar_tx` → 0 and `tx_credit_ok` 0. One more `nchar_tx` → cause 10, count 0.
- `tx_credit` 0, `fct_rx` and `nchar_tx` in the same cycle → 7, no error.
- `rx_buf_free` = 20 → one `fct_tx_req`. Ack → outstanding 8. Next request evaluates 20 ≥ 16 → second FCT, outstanding 16. Then 20 < 24 → no request.
- `rx_outstanding` 0, `rx_nchar` → cause 11, `fct_tx_req` stays 0. Drop `link_run` → all outputs 0.
- `reset_n` asserted while REQ is active with counts nonzero → all outputs 0 asynchronously. FSM is in IDLE after release.
